cart_bus_sequencer: RTL
=======================

Name: cart_bus_sequencer

Overview:
- Cycle-level controller for the 7800 cartridge bus interface.
- Consumes the already-synchronised Atari bus signals (address, PHI2, R/W, HALT) and sequences buffer direction, buffer enable, FPGA data-drive enable and the POKEY write strobe.
- Enforces a bus-turnaround guard and a PHI2 glitch filter, and samples write data at a programmed delay into PHI2-high.
- Sits between the input synchroniser registers and the ROM fetch, tristate and POKEY core.

Parameters:
- ROM_BASE, 16'h4000, lowest ROM address; ROM window is ROM_BASE..16'hFFFF.
- POKEY_BASE, 12'h045, a[15:4] match value for the POKEY register window.
- PHI2_FILT, 2, consecutive clk cycles phi2_sync must be high before a rise is accepted (1..7).
- WR_DELAY, 4, clk cycles after accepted PHI2 rise before write data is sampled (1..15).
- TURN_GUARD, 1, clk cycles buf_oe is held high after any drive/receive window closes (1..7).

Ports:
- clk  in  1  27 MHz system clock
- reset_n  in  1  asynchronous active-low reset
- a_sync  in  16  synchronised address bus
- phi2_sync  in  1  synchronised PHI2
- rw_sync  in  1  synchronised R/W (1 = read)
- halt_sync  in  1  synchronised HALT (0 = MARIA DMA)
- d_in  in  8  data bus input
- err_clr  in  1  clears err_short
- buf_dir  out  1  buffer direction (1 = cart drives Atari)
- buf_oe  out  1  buffer enable, active low
- d_oe  out  1  FPGA data pin drive enable
- rom_addr  out  16  a_sync - ROM_BASE, modulo 2^16
- pokey_we  out  1  one-clk POKEY write strobe
- pokey_addr  out  4  latched register index
- pokey_din  out  8  latched write data
- err_short  out  1  sticky: PHI2 fell before WR_DELAY elapsed
- state_dbg  out  3  current state encoding

Behaviour:
- Reset (async, takes effect immediately):
  - state = IDLE.
  - buf_oe = 1, buf_dir = 1, d_oe = 0, pokey_we = 0, pokey_addr = 0, pokey_din = 0, err_short = 0.
  - Filter and delay counters = 0.
- Outputs are registered Moore outputs and change on the same edge as the state register.
- rom_addr is combinational from a_sync.
- Decode:
  - is_rom = (a_sync >= ROM_BASE).
  - is_pokey = (a_sync[15:4] == POKEY_BASE).
- PHI2 filter: a 3-bit counter increments while phi2_sync = 1 and saturates; it clears when phi2_sync = 0. "rise" is a single pulse when the counter reaches PHI2_FILT.
- States:
  - IDLE: buf_oe = 1, d_oe = 0, buf_dir = rw_sync.
    - If halt_sync = 0, go to DMA (takes priority over rise).
    - Else on rise: rw_sync & is_rom -> RD; !rw_sync & is_pokey -> WR_WAIT (delay counter = 0); otherwise -> SKIP.
  - RD: buf_dir = 1, buf_oe = 0, d_oe = 1.
    - phi2_sync = 0 -> TURN.
    - halt_sync = 0 -> DMA with no guard gap (both are cart-drive windows).
  - WR_WAIT: buf_dir = 0, buf_oe = 0, d_oe = 0. The delay counter increments each clk.
    - When counter == WR_DELAY-1: latch pokey_din = d_in and pokey_addr = a_sync[3:0], then go to WR_STROBE.
    - If phi2_sync = 0 first: set err_short, issue no strobe, go to TURN.
    - HALT is ignored until the write completes.
  - WR_STROBE: pokey_we = 1 for exactly one clk, then WR_HOLD.
  - WR_HOLD: buf_oe = 0, buf_dir = 0. phi2_sync = 0 -> TURN.
  - SKIP: buf_oe = 1. phi2_sync = 0 -> IDLE.
  - DMA: buf_dir = 1.
    - buf_oe = 0 and d_oe = 1 while is_rom & rw_sync; otherwise buf_oe = 1 and d_oe = 0. Re-evaluated every clk.
    - halt_sync = 1 -> TURN.
  - TURN: buf_oe = 1, d_oe = 0, buf_dir = previous value held. After TURN_GUARD clks -> IDLE.
- Invariants:
  - d_oe = 1 implies buf_dir = 1 and buf_oe = 0.
  - buf_dir never changes on a cycle where buf_oe = 0 on both sides of the edge.
- At most one pokey_we pulse per PHI2 high phase.
- err_short is set by a short write and cleared by err_clr. When both happen in the same clk, set wins.
- rom_addr wraps, e.g. a_sync = 16'h3FFF gives 16'hFFFF; is_rom gates its use.

Test Plan:
- Reset held, random bus activity -> buf_oe = 1, d_oe = 0, pokey_we = 0 throughout. Release reset mid-PHI2-high -> no drive until the next filtered rise.
- CPU read at 16'h8000, PHI2 high for 7 clks -> RD entered PHI2_FILT clks after the rise; d_oe = 1 and buf_oe = 0 until the PHI2 fall; TURN buf_oe = 1 for 1 clk; rom_addr = 16'h4000.
- CPU write 8'hA5 to 16'h0452 -> exactly one pokey_we pulse; pokey_addr = 2 and pokey_din = 8'hA5; d_oe stays 0 for the whole cycle.
- Write to 16'h0458 with PHI2 high for only 4 clks (WR_DELAY = 4) -> no pokey_we, err_short = 1. Pulse err_clr -> err_short = 0.
- 1-clk PHI2 glitch, then read at 16'h0100 -> no state change on the glitch; SKIP on the read; buf_oe stays 1.
- HALT low during RD, then MARIA alternating 16'hC000 reads and 16'h2000 reads -> DMA entered with no gap; buf_oe toggles per address. HALT high -> TURN, then IDLE.

Source files
------------

// File: rtl/cart_bus_sequencer_if.sv
// Atari 7800 cartridge bus bundle: the synchronised bus inputs from the
// front-end registers and the buffer, drive and POKEY controls going back out.
// master = bus/environment side, slave = sequencer side.
interface cart_bus_sequencer_if;
  logic [15:0] a_sync;
  logic        phi2_sync;
  logic        rw_sync;
  logic        halt_sync;
  logic [7:0]  d_in;
  logic        err_clr;
  logic        buf_dir;
  logic        buf_oe;
  logic        d_oe;
  logic [15:0] rom_addr;
  logic        pokey_we;
  logic [3:0]  pokey_addr;
  logic [7:0]  pokey_din;
  logic        err_short;
  logic [2:0]  state_dbg;

  modport master (
    output a_sync, phi2_sync, rw_sync, halt_sync, d_in, err_clr,
    input  buf_dir, buf_oe, d_oe, rom_addr, pokey_we, pokey_addr,
           pokey_din, err_short, state_dbg
  );

  modport slave (
    input  a_sync, phi2_sync, rw_sync, halt_sync, d_in, err_clr,
    output buf_dir, buf_oe, d_oe, rom_addr, pokey_we, pokey_addr,
           pokey_din, err_short, state_dbg
  );
endinterface

// File: rtl/cart_bus_sequencer.sv
// Cycle-level sequencer for the 7800 cartridge bus. Filters PHI2, decodes the
// ROM and POKEY windows, and drives buffer direction/enable, the FPGA data
// drive and a one-clock POKEY write strobe. Buffer enable and data drive are
// all registered from the next state, so they move on the same edge as it.
// buf_oe is active low; buf_dir = 1 means the cart drives the Atari.
module cart_bus_sequencer #(
  parameter logic [15:0] ROM_BASE   = 16'h4000,
  parameter logic [11:0] POKEY_BASE = 12'h045,
  parameter int          PHI2_FILT  = 2,
  parameter int          WR_DELAY   = 4,
  parameter int          TURN_GUARD = 1
) (
  input logic                  clk,
  input logic                  reset_n,
  cart_bus_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RD        = 3'd1,
    S_WR_WAIT   = 3'd2,
    S_WR_STROBE = 3'd3,
    S_WR_HOLD   = 3'd4,
    S_SKIP      = 3'd5,
    S_DMA       = 3'd6,
    S_TURN      = 3'd7
  } state_t;

  localparam logic [2:0] FILT_LAST = 3'(PHI2_FILT - 1);
  localparam logic [3:0] DLY_LAST  = 4'(WR_DELAY - 1);
  localparam logic [3:0] TURN_LAST = 4'(TURN_GUARD - 1);

  state_t      state_q, state_d;
  logic [2:0]  filt_q, filt_d;
  logic [3:0]  dly_q, dly_d;
  logic        buf_dir_q, buf_dir_d;
  logic        buf_oe_q, buf_oe_d;
  logic        d_oe_q, d_oe_d;
  logic        pokey_we_q, pokey_we_d;
  logic [3:0]  pokey_addr_q, pokey_addr_d;
  logic [7:0]  pokey_din_q, pokey_din_d;
  logic        err_q, err_d;
  logic        err_set;
  logic        is_rom, is_pokey, rise;

  assign is_rom   = (bus.a_sync >= ROM_BASE);
  assign is_pokey = (bus.a_sync[15:4] == POKEY_BASE);
  // The counter passes PHI2_FILT-1 exactly once per high phase (it saturates
  // at 7), so this is a single pulse per accepted rise.
  assign rise     = bus.phi2_sync && (filt_q == FILT_LAST);

  // PHI2 glitch filter: count consecutive high samples, saturating at 7
  always_comb begin
    filt_d = 3'd0;
    if (bus.phi2_sync) filt_d = (filt_q == 3'd7) ? 3'd7 : filt_q + 3'd1;
  end

  // Next-state logic, write-data latch and sticky short-write flag.
  // dly counts write delay in WR_WAIT and guard length in TURN.
  always_comb begin
    state_d      = state_q;
    dly_d        = dly_q;
    pokey_addr_d = pokey_addr_q;
    pokey_din_d  = pokey_din_q;
    err_set      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!bus.halt_sync) begin
          state_d = S_DMA;
        end else if (rise) begin
          if (bus.rw_sync && is_rom) begin
            state_d = S_RD;
          end else if (!bus.rw_sync && is_pokey) begin
            state_d = S_WR_WAIT;
            dly_d   = 4'd0;
          end else begin
            state_d = S_SKIP;
          end
        end
      end
      S_RD: begin
        if (!bus.phi2_sync) begin
          state_d = S_TURN;
          dly_d   = 4'd0;
        end else if (!bus.halt_sync) begin
          state_d = S_DMA;
        end
      end
      S_WR_WAIT: begin
        if (!bus.phi2_sync) begin
          err_set = 1'b1;
          state_d = S_TURN;
          dly_d   = 4'd0;
        end else if (dly_q == DLY_LAST) begin
          pokey_din_d  = bus.d_in;
          pokey_addr_d = bus.a_sync[3:0];
          state_d      = S_WR_STROBE;
        end else begin
          dly_d = dly_q + 4'd1;
        end
      end
      S_WR_STROBE: state_d = S_WR_HOLD;
      S_WR_HOLD: begin
        if (!bus.phi2_sync) begin
          state_d = S_TURN;
          dly_d   = 4'd0;
        end
      end
      S_SKIP: begin
        if (!bus.phi2_sync) state_d = S_IDLE;
      end
      S_DMA: begin
        if (bus.halt_sync) begin
          state_d = S_TURN;
          dly_d   = 4'd0;
        end
      end
      S_TURN: begin
        if (dly_q == TURN_LAST) state_d = S_IDLE;
        else                    dly_d   = dly_q + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
    // A short write landing together with a clear leaves the flag set
    err_d = err_set ? 1'b1 : (bus.err_clr ? 1'b0 : err_q);
  end

  // Moore outputs for the state being entered; direction is held unless
  // the state defines it, so it never flips under an enabled buffer.
  always_comb begin
    buf_dir_d  = buf_dir_q;
    buf_oe_d   = 1'b1;
    d_oe_d     = 1'b0;
    pokey_we_d = 1'b0;
    case (state_d)
      S_IDLE: buf_dir_d = bus.rw_sync;
      S_RD: begin
        buf_dir_d = 1'b1;
        buf_oe_d  = 1'b0;
        d_oe_d    = 1'b1;
      end
      S_WR_WAIT, S_WR_HOLD: begin
        buf_dir_d = 1'b0;
        buf_oe_d  = 1'b0;
      end
      S_WR_STROBE: begin
        buf_dir_d  = 1'b0;
        buf_oe_d   = 1'b0;
        pokey_we_d = 1'b1;
      end
      S_DMA: begin
        buf_dir_d = 1'b1;
        if (is_rom && bus.rw_sync) begin
          buf_oe_d = 1'b0;
          d_oe_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      filt_q       <= 3'd0;
      dly_q        <= 4'd0;
      buf_dir_q    <= 1'b1;
      buf_oe_q     <= 1'b1;
      d_oe_q       <= 1'b0;
      pokey_we_q   <= 1'b0;
      pokey_addr_q <= 4'd0;
      pokey_din_q  <= 8'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      filt_q       <= filt_d;
      dly_q        <= dly_d;
      buf_dir_q    <= buf_dir_d;
      buf_oe_q     <= buf_oe_d;
      d_oe_q       <= d_oe_d;
      pokey_we_q   <= pokey_we_d;
      pokey_addr_q <= pokey_addr_d;
      pokey_din_q  <= pokey_din_d;
      err_q        <= err_d;
    end
  end

  assign bus.buf_dir    = buf_dir_q;
  assign bus.buf_oe     = buf_oe_q;
  assign bus.d_oe       = d_oe_q;
  assign bus.rom_addr   = bus.a_sync - ROM_BASE;
  assign bus.pokey_we   = pokey_we_q;
  assign bus.pokey_addr = pokey_addr_q;
  assign bus.pokey_din  = pokey_din_q;
  assign bus.err_short  = err_q;
  assign bus.state_dbg  = state_q;

endmodule
